add_serial_seq: RTL

// - Operand sequencer in front of the add_serial bit-serial adder.
// - Buffers operand pairs from a valid/ready source in a small FIFO and launches one add at a time.
// - Drives the adder's en/a/b, waits a fixed latency, captures the adder's 8-bit out, returns the adder to IDLE,
//   and presents the sum on a valid/ready result port.

---
 rtl/add_serial_seq_if.sv | 44 ++++
 rtl/add_serial_seq.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/add_serial_seq_if.sv
// rtl/add_serial_seq_if.sv - operand, adder and result signal bundle for add_serial_seq
// Purpose: groups the add_serial_seq handshake and bus signals.
// Modports:
//   slave  - sequencer view: consumes in_*, drives add_en/add_a/add_b, reads add_out,
//            drives res_valid/res_data, reads res_ready, drives busy (and err).
//   master - environment view: operand source, adder and result consumer.
// Optional: ADD_SEQ_CHECK_EN adds the err signal.
interface add_serial_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             add_en;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             busy;
`ifdef ADD_SEQ_CHECK_EN
  logic             err;
`endif

  modport slave (
    input  in_valid, in_a, in_b, add_out, res_ready,
    output in_ready, add_en, add_a, add_b, res_valid, res_data,
    output busy
`ifdef ADD_SEQ_CHECK_EN
    , output err
`endif
  );

  modport master (
    output in_valid, in_a, in_b, add_out, res_ready,
    input  in_ready, add_en, add_a, add_b, res_valid, res_data,
    input  busy
`ifdef ADD_SEQ_CHECK_EN
    , input err
`endif
  );
endinterface

// File: rtl/add_serial_seq.sv
// rtl/add_serial_seq.sv - operand sequencer in front of the add_serial bit-serial adder
// Purpose: buffers operand pairs in a FIFO, launches one add at a time on the adder
//   (en pulse, fixed wait, capture, release pulse) and returns sums on a valid/ready port.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - add_serial_seq_if.slave: in_valid/in_ready/in_a/in_b operand port,
//          add_en/add_a/add_b/add_out adder port, res_valid/res_ready/res_data result port,
//          busy status, err (only with ADD_SEQ_CHECK_EN).
// Optional: define ADD_SEQ_CHECK_EN to add a sticky err flag that compares the captured
//   adder output against add_a+add_b.
module add_serial_seq #(
  parameter int WIDTH       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADD_LATENCY = 12
) (
  input logic             clk,
  input logic             rst,
  add_serial_seq_if.slave bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W = (ADD_LATENCY > 1) ? $clog2(ADD_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_CAPT  = 3'd3,
    S_REL   = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem_a [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_b [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push, pop, fifo_empty;

  logic [LAT_W-1:0] lat_cnt;
  logic             add_en_q, res_valid_q;
  logic [WIDTH-1:0] add_a_q, add_b_q, res_data_q;
  logic             launch, clr_lat, inc_lat, capture, en_d;

  // ---------------- operand FIFO ----------------
  assign fifo_empty   = (count == '0);
  assign bus.in_ready = (count != CNT_W'(FIFO_DEPTH));
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = launch;

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_a;
      mem_b[wr_ptr] <= bus.in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Launch only from registered FIFO count (no bypass) and only once the previous
  // result has been taken, so res_data is never overwritten.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty && !res_valid_q) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (lat_cnt == LAT_W'(ADD_LATENCY - 1)) state_d = S_CAPT;
      S_CAPT:  state_d = S_REL;
      S_REL:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // add_en is registered, so it is decoded from the state being entered:
  // high while in S_ISSUE (start) and S_REL (DONE->IDLE release).
  always_comb begin
    launch  = (state_q == S_IDLE) && (state_d == S_ISSUE);
    clr_lat = (state_q == S_ISSUE);
    inc_lat = (state_q == S_WAIT);
    capture = (state_q == S_CAPT);
    en_d    = (state_d == S_ISSUE) || (state_d == S_REL);
  end

  // ---------------- datapath / registered outputs ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_en_q    <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      lat_cnt     <= '0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      add_en_q <= en_d;
      if (launch) begin
        add_a_q <= mem_a[rd_ptr];
        add_b_q <= mem_b[rd_ptr];
      end
      if (clr_lat)      lat_cnt <= '0;
      else if (inc_lat) lat_cnt <= lat_cnt + LAT_W'(1);
      if (capture) begin
        res_data_q  <= bus.add_out;
        res_valid_q <= 1'b1;
      end else if (res_valid_q && bus.res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.add_en    = add_en_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = (state_q != S_IDLE) || !fifo_empty;

`ifdef ADD_SEQ_CHECK_EN
  logic [WIDTH-1:0] sum_chk;
  logic             err_q;

  assign sum_chk = add_a_q + add_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 err_q <= 1'b0;
    else if (capture && bus.add_out != sum_chk) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`endif
endmodule
